// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - MEM stage FSM state and MEM/WB bubble definitions
package mem_stage_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic [31:0] alu_out;
      logic [31:0] read_data;
      logic        mem_to_reg;
      logic        reg_wre;
      logic [4:0]  reg_rd;
   } mem_wb_t;

   localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register, loads real data or a bubble every edge
module mem_wb_reg
   import mem_stage_pkg::*;
(
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    load_data_i,
   input  mem_wb_t data_i,
   output mem_wb_t q_o
);

   mem_wb_t wb_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wb_q <= MEM_WB_BUBBLE;
      end else if (load_data_i) begin
         wb_q <= data_i;
      end else begin
         wb_q <= MEM_WB_BUBBLE;
      end
   end

   assign q_o = wb_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: req/ack data access, stall, timeout abort, MEM/WB
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses are suppressed and flagged with MEM_Misalign.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int ACK_TIMEOUT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EX_MEM_Read_Con,
   input  logic        EX_MEM_Write_Con,
   input  logic [31:0] EX_MEM_ALUOut,
   input  logic [31:0] EX_MEM_WriteData,
   input  logic        EX_MEM_MEMtoReg,
   input  logic        EX_MEM_RegWre,
   input  logic [4:0]  EX_MEM_Reg_RD,
   output logic        DMem_Req,
   output logic        DMem_We,
   output logic [31:0] DMem_Addr,
   output logic [31:0] DMem_WData,
   input  logic [31:0] DMem_RData,
   input  logic        DMem_Ack,
   output logic        MEM_Stall,
   output logic [31:0] MEM_WB_ALUOut,
   output logic [31:0] MEM_WB_ReadData,
   output logic        MEM_WB_MEMtoReg,
   output logic        MEM_WB_RegWre,
   output logic [4:0]  MEM_WB_Reg_RD,
   output logic        MEM_BusErr,
   output logic        MEM_Misalign
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   mem_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          access, is_load, misaligned;
   logic          req, abort, load_data;
   logic          bus_err_q;
   mem_wb_t       wb_d, wb_q;

   assign access  = EX_MEM_Read_Con | EX_MEM_Write_Con;
   assign is_load = EX_MEM_Read_Con & ~EX_MEM_Write_Con;

`ifdef MEM_ALIGN_CHECK_EN
   logic misalign_q;

   assign misaligned = access & (EX_MEM_ALUOut[1:0] != 2'b00);
   assign DMem_Addr  = EX_MEM_ALUOut;

   always_ff @(posedge CLK) begin
      if (RST) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= (state_q == IDLE) & misaligned;
      end
   end

   assign MEM_Misalign = misalign_q;
`else
   assign misaligned   = 1'b0;
   assign DMem_Addr    = {EX_MEM_ALUOut[31:2], 2'b00};
   assign MEM_Misalign = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bus_err_q <= abort;
      end
   end

   // cnt_q holds the count of the current WAIT_ACK cycle; the issue cycle is count 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: begin
            if (access & ~misaligned & ~DMem_Ack) begin
               state_d = WAIT_ACK;
               cnt_d   = CW'(2);
            end
         end
         WAIT_ACK: begin
            if (DMem_Ack || (cnt_q == CW'(ACK_TIMEOUT))) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req       = 1'b0;
      abort     = 1'b0;
      load_data = 1'b0;
      case (state_q)
         IDLE: begin
            req       = access & ~misaligned;
            load_data = ~access | (access & ~misaligned & DMem_Ack);
         end
         WAIT_ACK: begin
            req       = 1'b1;
            abort     = ~DMem_Ack & (cnt_q == CW'(ACK_TIMEOUT));
            load_data = DMem_Ack;
         end
         default: ;
      endcase
      if (RST) begin
         req = 1'b0;
      end
   end

   assign DMem_Req   = req;
   assign DMem_We    = EX_MEM_Write_Con;
   assign DMem_WData = EX_MEM_WriteData;
   assign MEM_Stall  = req & ~DMem_Ack & ~abort;
   assign MEM_BusErr = bus_err_q;

   assign wb_d.alu_out    = EX_MEM_ALUOut;
   assign wb_d.read_data  = (is_load & DMem_Ack) ? DMem_RData : 32'h0;
   assign wb_d.mem_to_reg = EX_MEM_MEMtoReg;
   assign wb_d.reg_wre    = EX_MEM_RegWre;
   assign wb_d.reg_rd     = EX_MEM_Reg_RD;

   mem_wb_reg u_mem_wb_reg (
      .clk_i       (CLK),
      .rst_i       (RST),
      .load_data_i (load_data),
      .data_i      (wb_d),
      .q_o         (wb_q)
   );

   assign MEM_WB_ALUOut   = wb_q.alu_out;
   assign MEM_WB_ReadData = wb_q.read_data;
   assign MEM_WB_MEMtoReg = wb_q.mem_to_reg;
   assign MEM_WB_RegWre   = wb_q.reg_wre;
   assign MEM_WB_Reg_RD   = wb_q.reg_rd;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage (ACK_TIMEOUT = 4)
module tb_mem_access_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EX_MEM_Read_Con, EX_MEM_Write_Con, EX_MEM_MEMtoReg, EX_MEM_RegWre;
   logic [31:0] EX_MEM_ALUOut, EX_MEM_WriteData, DMem_RData;
   logic [4:0]  EX_MEM_Reg_RD;
   logic        DMem_Ack;
   logic        DMem_Req, DMem_We, MEM_Stall;
   logic [31:0] DMem_Addr, DMem_WData, MEM_WB_ALUOut, MEM_WB_ReadData;
   logic        MEM_WB_MEMtoReg, MEM_WB_RegWre, MEM_BusErr, MEM_Misalign;
   logic [4:0]  MEM_WB_Reg_RD;

   int total = 0;
   int bad   = 0;
   int stall_cnt;

   always #5 CLK = ~CLK;

   mem_access_stage #(.ACK_TIMEOUT(4)) dut (
      .CLK              (CLK),
      .RST              (RST),
      .EX_MEM_Read_Con  (EX_MEM_Read_Con),
      .EX_MEM_Write_Con (EX_MEM_Write_Con),
      .EX_MEM_ALUOut    (EX_MEM_ALUOut),
      .EX_MEM_WriteData (EX_MEM_WriteData),
      .EX_MEM_MEMtoReg  (EX_MEM_MEMtoReg),
      .EX_MEM_RegWre    (EX_MEM_RegWre),
      .EX_MEM_Reg_RD    (EX_MEM_Reg_RD),
      .DMem_Req         (DMem_Req),
      .DMem_We          (DMem_We),
      .DMem_Addr        (DMem_Addr),
      .DMem_WData       (DMem_WData),
      .DMem_RData       (DMem_RData),
      .DMem_Ack         (DMem_Ack),
      .MEM_Stall        (MEM_Stall),
      .MEM_WB_ALUOut    (MEM_WB_ALUOut),
      .MEM_WB_ReadData  (MEM_WB_ReadData),
      .MEM_WB_MEMtoReg  (MEM_WB_MEMtoReg),
      .MEM_WB_RegWre    (MEM_WB_RegWre),
      .MEM_WB_Reg_RD    (MEM_WB_Reg_RD),
      .MEM_BusErr       (MEM_BusErr),
      .MEM_Misalign     (MEM_Misalign)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      EX_MEM_Read_Con  = 1'b0;
      EX_MEM_Write_Con = 1'b0;
      EX_MEM_ALUOut    = 32'h0;
      EX_MEM_WriteData = 32'h0;
      EX_MEM_MEMtoReg  = 1'b0;
      EX_MEM_RegWre    = 1'b0;
      EX_MEM_Reg_RD    = 5'd0;
      DMem_Ack         = 1'b0;
      DMem_RData       = 32'h0;
   endtask

   task automatic edge_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_wb_zero(input string tag);
      chk({tag, "_alu"},  MEM_WB_ALUOut, 32'h0);
      chk({tag, "_rd"},   MEM_WB_ReadData, 32'h0);
      chk({tag, "_m2r"},  MEM_WB_MEMtoReg, 1'b0);
      chk({tag, "_wre"},  MEM_WB_RegWre, 1'b0);
      chk({tag, "_dst"},  MEM_WB_Reg_RD, 5'd0);
      chk({tag, "_berr"}, MEM_BusErr, 1'b0);
      chk({tag, "_mis"},  MEM_Misalign, 1'b0);
   endtask

   initial begin
      idle_inputs();
      RST = 1'b1;
      edge_step();
      edge_step();
      chk("rst_req", DMem_Req, 1'b0);
      chk_wb_zero("rst");
      RST = 1'b0;

      // ALU op, no memory access
      EX_MEM_ALUOut = 32'h0000_1234; EX_MEM_RegWre = 1'b1; EX_MEM_Reg_RD = 5'd5;
      #2;
      chk("alu_req", DMem_Req, 1'b0);
      chk("alu_stall", MEM_Stall, 1'b0);
      edge_step();
      chk("alu_wb_alu", MEM_WB_ALUOut, 32'h0000_1234);
      chk("alu_wb_wre", MEM_WB_RegWre, 1'b1);
      chk("alu_wb_dst", MEM_WB_Reg_RD, 5'd5);
      chk("alu_wb_rdata", MEM_WB_ReadData, 32'h0);
      chk("alu_wb_m2r", MEM_WB_MEMtoReg, 1'b0);
      idle_inputs();

      // zero-wait load
      EX_MEM_Read_Con = 1'b1; EX_MEM_ALUOut = 32'h100; EX_MEM_MEMtoReg = 1'b1;
      EX_MEM_RegWre = 1'b1; EX_MEM_Reg_RD = 5'd7; DMem_Ack = 1'b1; DMem_RData = 32'hDEAD_BEEF;
      #2;
      chk("ld0_req", DMem_Req, 1'b1);
      chk("ld0_we", DMem_We, 1'b0);
      chk("ld0_addr", DMem_Addr, 32'h100);
      chk("ld0_stall", MEM_Stall, 1'b0);
      edge_step();
      chk("ld0_wb_rdata", MEM_WB_ReadData, 32'hDEAD_BEEF);
      chk("ld0_wb_m2r", MEM_WB_MEMtoReg, 1'b1);
      chk("ld0_wb_wre", MEM_WB_RegWre, 1'b1);
      chk("ld0_wb_dst", MEM_WB_Reg_RD, 5'd7);
      chk("ld0_wb_alu", MEM_WB_ALUOut, 32'h100);
      idle_inputs();

      // store with 3 wait cycles
      EX_MEM_Write_Con = 1'b1; EX_MEM_ALUOut = 32'h40; EX_MEM_WriteData = 32'hA5A5_A5A5;
      stall_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("st_req", DMem_Req, 1'b1);
         chk("st_we", DMem_We, 1'b1);
         chk("st_addr", DMem_Addr, 32'h40);
         chk("st_wdata", DMem_WData, 32'hA5A5_A5A5);
         if (MEM_Stall) stall_cnt++;
         edge_step();
         chk("st_wb_wre", MEM_WB_RegWre, 1'b0);
      end
      DMem_Ack = 1'b1;
      #2;
      chk("st_ack_req", DMem_Req, 1'b1);
      if (MEM_Stall) stall_cnt++;
      chk("st_stall_cycles", stall_cnt, 3);
      edge_step();
      chk("st_wb_wre_done", MEM_WB_RegWre, 1'b0);
      chk("st_wb_alu_done", MEM_WB_ALUOut, 32'h40);
      chk("st_wb_rdata", MEM_WB_ReadData, 32'h0);
      chk("st_berr", MEM_BusErr, 1'b0);
      idle_inputs();

      // load with no Ack: timeout after 4 cycles
      EX_MEM_Read_Con = 1'b1; EX_MEM_ALUOut = 32'h200; EX_MEM_MEMtoReg = 1'b1;
      EX_MEM_RegWre = 1'b1; EX_MEM_Reg_RD = 5'd9;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("to_req", DMem_Req, 1'b1);
         chk("to_stall", MEM_Stall, (i < 3) ? 1'b1 : 1'b0);
         edge_step();
         chk("to_berr", MEM_BusErr, (i == 3) ? 1'b1 : 1'b0);
         chk("to_wb_wre", MEM_WB_RegWre, 1'b0);
         chk("to_wb_m2r", MEM_WB_MEMtoReg, 1'b0);
      end
      idle_inputs();
      DMem_Ack = 1'b1; DMem_RData = 32'h5555_5555;
      #2;
      chk("late_req", DMem_Req, 1'b0);
      chk("late_stall", MEM_Stall, 1'b0);
      edge_step();
      chk("late_berr", MEM_BusErr, 1'b0);
      chk("late_wb_wre", MEM_WB_RegWre, 1'b0);
      chk("late_wb_rdata", MEM_WB_ReadData, 32'h0);
      idle_inputs();

      // misaligned load at 0x102
      EX_MEM_Read_Con = 1'b1; EX_MEM_ALUOut = 32'h102; EX_MEM_MEMtoReg = 1'b1;
      EX_MEM_RegWre = 1'b1; EX_MEM_Reg_RD = 5'd3; DMem_Ack = 1'b1; DMem_RData = 32'h1122_3344;
      #2;
`ifdef MEM_ALIGN_CHECK_EN
      chk("mis_req", DMem_Req, 1'b0);
      chk("mis_stall", MEM_Stall, 1'b0);
      edge_step();
      chk("mis_pulse", MEM_Misalign, 1'b1);
      chk("mis_wb_wre", MEM_WB_RegWre, 1'b0);
      idle_inputs();
      edge_step();
      chk("mis_pulse_end", MEM_Misalign, 1'b0);
`else
      chk("mis_req", DMem_Req, 1'b1);
      chk("mis_addr", DMem_Addr, 32'h100);
      chk("mis_stall", MEM_Stall, 1'b0);
      edge_step();
      chk("mis_wb_rdata", MEM_WB_ReadData, 32'h1122_3344);
      chk("mis_wb_wre", MEM_WB_RegWre, 1'b1);
      chk("mis_pulse", MEM_Misalign, 1'b0);
      idle_inputs();
`endif

      // reset in the second WAIT_ACK cycle
      EX_MEM_Read_Con = 1'b1; EX_MEM_ALUOut = 32'h80; EX_MEM_MEMtoReg = 1'b1;
      EX_MEM_RegWre = 1'b1; EX_MEM_Reg_RD = 5'd4;
      #2;
      chk("rw_issue_req", DMem_Req, 1'b1);
      edge_step();
      edge_step();
      RST = 1'b1;
      #2;
      chk("rw_rst_req", DMem_Req, 1'b0);
      edge_step();
      chk_wb_zero("rw_rst");
      RST = 1'b0;
      idle_inputs();
      DMem_Ack = 1'b1;
      #2;
      chk("rw_late_req", DMem_Req, 1'b0);
      edge_step();
      chk("rw_late_wre", MEM_WB_RegWre, 1'b0);
      idle_inputs();

      // normal one-wait load after reset
      EX_MEM_Read_Con = 1'b1; EX_MEM_ALUOut = 32'h300; EX_MEM_MEMtoReg = 1'b1;
      EX_MEM_RegWre = 1'b1; EX_MEM_Reg_RD = 5'd2; DMem_RData = 32'hCAFE_F00D;
      #2;
      chk("post_stall0", MEM_Stall, 1'b1);
      edge_step();
      DMem_Ack = 1'b1;
      #2;
      chk("post_stall1", MEM_Stall, 1'b0);
      edge_step();
      chk("post_wb_rdata", MEM_WB_ReadData, 32'hCAFE_F00D);
      chk("post_wb_wre", MEM_WB_RegWre, 1'b1);
      chk("post_wb_dst", MEM_WB_Reg_RD, 5'd2);
      idle_inputs();
      edge_step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
